// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// Used by fetch_fifo and fetch_queue.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {pc, instr} fetch entries with flush.
// The head slot is always visible combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [PW:0]  count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Flush wins over both push and pop; pop is ignored on an empty FIFO.
  always_comb begin
    do_push  = push_i & ~flush_i;
    do_pop   = pop_i & ~flush_i & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + (PW+1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, imem request issue, response buffering, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic        misalign_o
);

  localparam int PW = ptr_w(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [PW:0]   count;
  logic [PW+1:0] occupancy;
  fetch_entry_t  head, push_entry;
  logic          issue, push, pop, out_valid;
  logic          halted;
  logic [31:0]   target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q, halted_d;
  logic misalign_q, misalign_d;

  always_comb begin
    halted_d   = halted_q;
    misalign_d = misalign_q;
    if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
      halted_d   = 1'b1;
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign halted     = halted_q;
  assign misalign_o = misalign_q;
  assign target_pc  = redirect_pc_i;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc_i[1:0];
  assign halted         = 1'b0;
  assign misalign_o     = 1'b0;
  assign target_pc      = {redirect_pc_i[31:2], 2'b00};
`endif

  // A slot is reserved for the in-flight response, so issue only if it will fit.
  assign occupancy  = {1'b0, count} + (PW+2)'(inflight_q);
  assign issue      = ~rst_i & start_i & ~redirect_i & ~halted & (occupancy < (PW+2)'(DEPTH));
  assign out_valid  = (count != '0) & ~redirect_i;
  assign pop        = out_valid & out_ready_i;
  assign push       = inflight_q & ~redirect_i;
  assign push_entry = '{pc: inflight_pc_q, instr: imem_data_i};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_i) begin
      pc_d = target_pc;
    end else if (issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .flush_i    (redirect_i),
    .count_o    (count),
    .head_o     (head)
  );

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign out_valid_o = out_valid;
  assign out_pc_o    = head.pc;
  assign out_instr_o = head.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0, redirect_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_data_i = '0;
  logic        imem_req_o, out_valid_o, misalign_o;
  logic [31:0] imem_addr_o, out_pc_o, out_instr_o;

  logic        start2 = 1'b0;
  logic        req2, valid2, mis2;
  logic [31:0] addr2, pc2, instr2;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h00000000)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_instr_o(out_instr_o), .misalign_o(misalign_o)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFFFFF8)) u_wrap (
    .clk_i(clk), .rst_i(rst_i), .start_i(start2), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_data_i(32'h0), .out_valid_o(valid2), .out_ready_i(1'b1),
    .out_pc_o(pc2), .out_instr_o(instr2), .misalign_o(mis2)
  );

  // Reference model: a plain queue of fetched entries plus the pending request.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_infl_pc;
  bit          m_infl, m_halt, m_mis;
  bit          use_hash;
  int          n_vec = 0, n_bad = 0;

  typedef struct {
    bit          rst_before;
    bit          start, rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[15];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return use_hash ? ({a[15:0], a[31:16]} ^ 32'h5A5A1234) : a;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_infl = 0; m_infl_pc = 32'h0; m_halt = 0; m_mis = 0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rst_i = 1'b1;
    #1;
    check32("rst_req",   32'(imem_req_o),  32'h0);
    check32("rst_valid", 32'(out_valid_o), 32'h0);
    check32("rst_addr",  imem_addr_o,      32'h0);
    check32("rst_mis",   32'(misalign_o),  32'h0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
    imem_data_i = $urandom();
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance model at posedge.
  task automatic step(input bit s, input bit r, input logic [31:0] rpc, input bit rdy,
                      output bit o_req, output bit o_valid,
                      output logic [31:0] o_addr, output logic [31:0] o_pc);
    bit          e_req, e_valid;
    logic [31:0] e_addr;
    start_i = s; redirect_i = r; redirect_pc_i = rpc; out_ready_i = rdy;
    @(negedge clk);
    e_req   = s && !r && !m_halt && ((mq.size() + int'(m_infl)) < 4);
    e_valid = (mq.size() != 0) && !r;
    e_addr  = m_pc;
    check32("req",   32'(imem_req_o),  32'(e_req));
    check32("addr",  imem_addr_o,      e_addr);
    check32("valid", 32'(out_valid_o), 32'(e_valid));
    check32("mis",   32'(misalign_o),  32'(m_mis));
    if (e_valid) begin
      check32("out_pc",    out_pc_o,    mq[0].pc);
      check32("out_instr", out_instr_o, mq[0].instr);
    end
    o_req = imem_req_o; o_valid = out_valid_o; o_addr = imem_addr_o; o_pc = out_pc_o;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_infl = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) begin m_mis = 1; m_halt = 1; end
      m_pc = rpc;
`else
      m_pc = {rpc[31:2], 2'b00};
`endif
    end else begin
      if (e_valid && rdy) void'(mq.pop_front());
      if (m_infl) mq.push_back('{pc: m_infl_pc, instr: imem_data_i});
      m_infl = e_req;
      if (e_req) begin m_infl_pc = m_pc; m_pc = m_pc + 32'd4; end
    end
    #1 imem_data_i = e_req ? mem_word(e_addr) : $urandom();
  endtask

  initial begin
    bit          q_req, q_valid;
    logic [31:0] q_addr, q_pc;

    // rst, start, rdy, req, addr, valid, pc
    tbl[0]  = '{1, 1, 1, 1, 32'h00, 0, 32'h0};
    tbl[1]  = '{0, 1, 1, 1, 32'h04, 0, 32'h0};
    tbl[2]  = '{0, 1, 1, 1, 32'h08, 1, 32'h0};
    tbl[3]  = '{0, 1, 1, 1, 32'h0C, 1, 32'h4};
    tbl[4]  = '{0, 1, 1, 1, 32'h10, 1, 32'h8};
    tbl[5]  = '{0, 1, 1, 1, 32'h14, 1, 32'hC};
    tbl[6]  = '{1, 1, 0, 1, 32'h00, 0, 32'h0};
    tbl[7]  = '{0, 1, 0, 1, 32'h04, 0, 32'h0};
    tbl[8]  = '{0, 1, 0, 1, 32'h08, 1, 32'h0};
    tbl[9]  = '{0, 1, 0, 1, 32'h0C, 1, 32'h0};
    tbl[10] = '{0, 1, 0, 0, 32'h10, 1, 32'h0};
    tbl[11] = '{0, 1, 0, 0, 32'h10, 1, 32'h0};
    tbl[12] = '{0, 1, 1, 0, 32'h10, 1, 32'h0};
    tbl[13] = '{0, 1, 1, 1, 32'h10, 1, 32'h4};
    tbl[14] = '{0, 1, 1, 1, 32'h14, 1, 32'h8};

    use_hash = 0;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst_before) begin start_i = 1'b0; async_reset(); end
      step(tbl[i].start, 0, 32'h0, tbl[i].rdy, q_req, q_valid, q_addr, q_pc);
      check32($sformatf("tbl%0d_req", i),   32'(q_req),   32'(tbl[i].exp_req));
      check32($sformatf("tbl%0d_addr", i),  q_addr,       tbl[i].exp_addr);
      check32($sformatf("tbl%0d_valid", i), 32'(q_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check32($sformatf("tbl%0d_pc", i), q_pc, tbl[i].exp_pc);
    end

    // Redirect with 3 buffered entries and 1 in flight.
    use_hash = 1;
    start_i = 1'b0;
    async_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 0, q_req, q_valid, q_addr, q_pc);
    step(1, 1, 32'h100, 0, q_req, q_valid, q_addr, q_pc);
    check32("redir_valid", 32'(q_valid), 32'h0);
    step(1, 0, 32'h0, 1, q_req, q_valid, q_addr, q_pc);
    check32("redir_next_req",  32'(q_req), 32'h1);
    check32("redir_next_addr", q_addr,     32'h100);
    check32("redir_empty",     32'(q_valid), 32'h0);
    step(1, 0, 32'h0, 1, q_req, q_valid, q_addr, q_pc);
    check32("redir_still_empty", 32'(q_valid), 32'h0);
    step(1, 0, 32'h0, 1, q_req, q_valid, q_addr, q_pc);
    check32("redir_first_valid", 32'(q_valid), 32'h1);
    check32("redir_first_pc",    q_pc,         32'h100);

    // Wrap of the PC from a high reset value (second instance).
    start_i = 1'b0;
    async_reset();
    for (int i = 0; i < 3; i++) begin
      start2 = 1'b1;
      @(negedge clk);
      check32($sformatf("wrap_req%0d", i),  32'(req2), 32'h1);
      check32($sformatf("wrap_addr%0d", i), addr2,     32'hFFFFFFF8 + 32'(4 * i));
      if (i == 2) check32("wrap_head_pc", pc2, 32'hFFFFFFF8);
      @(posedge clk);
      #1;
    end
    start2 = 1'b0;

    // Asynchronous reset in the middle of streaming.
    async_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 32'h0, i[0], q_req, q_valid, q_addr, q_pc);
    start_i = 1'b1;
    async_reset();
    step(1, 0, 32'h0, 1, q_req, q_valid, q_addr, q_pc);
    check32("refetch_addr", q_addr, 32'h0);

    // Misaligned redirect target.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 1, q_req, q_valid, q_addr, q_pc);
    step(1, 1, 32'h102, 1, q_req, q_valid, q_addr, q_pc);
    step(1, 0, 32'h0, 1, q_req, q_valid, q_addr, q_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
    check32("mis_flag", 32'(misalign_o), 32'h1);
    check32("mis_noreq", 32'(q_req), 32'h0);
`else
    check32("mis_flag", 32'(misalign_o), 32'h0);
    check32("mis_addr", q_addr, 32'h100);
`endif
    for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 1, q_req, q_valid, q_addr, q_pc);

    // Randomized traffic against the model.
    start_i = 1'b0;
    async_reset();
    for (int i = 0; i < 400; i++) begin
      bit          rs, rr, rd;
      logic [31:0] rpc;
      rs  = ($urandom_range(0, 99) < 85);
      rr  = ($urandom_range(0, 99) < 7);
      rd  = ($urandom_range(0, 99) < 65);
      rpc = $urandom() & 32'h0000FFFC;
      step(rs, rr, rpc, rd, q_req, q_valid, q_addr, q_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
